// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes and
// variable-latency data-memory freeze with a timeout watchdog.
module hazard_stall_unit #(
   parameter int MEM_TIMEOUT = 255,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4:0]             IF_ID_rs1,
   input  logic [4:0]             IF_ID_rs2,
   input  logic                   IF_ID_uses_rs1,
   input  logic                   IF_ID_uses_rs2,
   input  logic                   ID_EX_mem_read,
   input  logic [4:0]             ID_EX_rd,
   input  logic                   EX_MEM_mem_read,
   input  logic                   EX_MEM_mem_write,
   input  logic                   mem_ready,
   input  logic                   branch_taken,
   output logic                   pc_write,
   output logic                   IF_ID_write,
   output logic                   IF_ID_flush,
   output logic                   ID_EX_flush,
   output logic                   pipe_hold,
   output logic                   mem_timeout,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
   localparam logic [WCW-1:0] TMO_VAL = WCW'(MEM_TIMEOUT);
   localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {ST_RUN, ST_WAIT, ST_ERROR} state_e;

   state_e                 state_q, state_d;
   logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
   logic                   mem_timeout_q, mem_timeout_d;
   logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

   logic load_use;
   logic mem_busy;

   assign load_use = ID_EX_mem_read & (ID_EX_rd != 5'd0) &
                     ((IF_ID_uses_rs1 & (IF_ID_rs1 == ID_EX_rd)) |
                      (IF_ID_uses_rs2 & (IF_ID_rs2 == ID_EX_rd)));
   assign mem_busy = (EX_MEM_mem_read | EX_MEM_mem_write) & ~mem_ready;

   // Mealy decode: a memory stall outranks a branch, which squashes any load-use.
   always_comb begin
      pc_write    = 1'b1;
      IF_ID_write = 1'b1;
      IF_ID_flush = 1'b0;
      ID_EX_flush = 1'b0;
      pipe_hold   = 1'b0;
      if (!rst_n) begin
         pc_write    = 1'b0;
         IF_ID_write = 1'b0;
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (state_q == ST_ERROR || mem_busy) begin
         pc_write    = 1'b0;
         IF_ID_write = 1'b0;
         pipe_hold   = 1'b1;
      end else if (branch_taken) begin
         IF_ID_flush = 1'b1;
         ID_EX_flush = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         IF_ID_write = 1'b0;
         ID_EX_flush = 1'b1;
      end
   end

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      case (state_q)
         ST_RUN: begin
            if (mem_busy) begin
               state_d    = ST_WAIT;
               wait_cnt_d = WCW'(1);
            end
         end
         ST_WAIT: begin
            if (!mem_busy) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else if (TIMEOUT_EN && wait_cnt_q == TMO_VAL) begin
               state_d       = ST_ERROR;
               mem_timeout_d = 1'b1;
            end else if (TIMEOUT_EN) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ST_ERROR: mem_timeout_d = 1'b1;
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Cycles spent in the error freeze are not counted as stalls.
   always_comb begin
      stall_count_d = stall_count_q;
      if (!pc_write && state_q != ST_ERROR && stall_count_q != CNT_MAX)
         stall_count_d = stall_count_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign mem_timeout = mem_timeout_q;
   assign stall_count = stall_count_q;

endmodule
